// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART stream bridge.
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitBusy,
        StWaitDone
    } tx_state_e;

    localparam int unsigned BusyTimeout = 2;
    localparam int unsigned WaitCntW    = $clog2(BusyTimeout + 1);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty/level derived from the pointer difference.
module sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_do_push;
    logic              w_do_pop;

    assign o_level = r_wptr - r_rptr;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/uart_stream_bridge.sv
// Bridges UART rx bytes through a processor or matched-latency bypass into a FIFO,
// then paces them out to the UART transmitter; also provides a heartbeat.
module uart_stream_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned PROC_LAT = 1,
    parameter int unsigned HB_DIV   = 10000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rx_done,
    input  logic [DATA_W-1:0]      i_rx_data,
    input  logic                   i_bypass,
    output logic                   o_proc_en,
    output logic [DATA_W-1:0]      o_proc_in,
    input  logic [DATA_W-1:0]      i_proc_out,
    input  logic                   i_tx_busy,
    output logic                   o_tx_start,
    output logic [DATA_W-1:0]      o_tx_data,
    output logic [$clog2(DEPTH):0] o_fifo_level,
    output logic                   o_overflow,
    output logic                   o_heartbeat
);

    localparam int unsigned HbW = $clog2(HB_DIV);

    logic                             r_rx_hist;
    logic                             r_proc_en;
    logic [DATA_W-1:0]                r_proc_in;
    logic [PROC_LAT:0]                r_pipe_vld;
    logic [PROC_LAT:0]                r_pipe_byp;
    logic [PROC_LAT:0][DATA_W-1:0]    r_pipe_dat;
    logic                             r_overflow;
    logic [HbW-1:0]                   r_hb_cnt;
    logic                             r_heartbeat;
    tx_state_e                        r_state;
    logic                             r_tx_start;
    logic [DATA_W-1:0]                r_tx_data;
    logic [WaitCntW-1:0]              r_wait_cnt;

    logic                             w_capture;
    logic                             w_push;
    logic [DATA_W-1:0]                w_push_data;
    logic                             w_pop;
    logic [DATA_W-1:0]                w_fifo_rdata;
    logic                             w_fifo_full;
    logic                             w_fifo_empty;

    assign w_capture = i_rx_done && !r_rx_hist;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_hist <= 1'b1;
            r_proc_en <= 1'b0;
            r_proc_in <= '0;
        end else begin
            r_rx_hist <= i_rx_done;
            r_proc_en <= w_capture;
            if (w_capture) begin
                r_proc_in <= i_rx_data;
            end
        end
    end

    // One extra stage so the token exits exactly when the processor result is valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pipe_vld <= '0;
            r_pipe_byp <= '0;
            r_pipe_dat <= '0;
        end else begin
            r_pipe_vld <= {r_pipe_vld[PROC_LAT-1:0], w_capture};
            r_pipe_byp <= {r_pipe_byp[PROC_LAT-1:0], i_bypass};
            r_pipe_dat <= {r_pipe_dat[PROC_LAT-1:0], i_rx_data};
        end
    end

    assign w_push      = r_pipe_vld[PROC_LAT];
    assign w_push_data = r_pipe_byp[PROC_LAT] ? r_pipe_dat[PROC_LAT] : i_proc_out;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (o_fifo_level)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign w_pop = (r_state == StIdle) && !w_fifo_empty && !i_tx_busy;

    // Busy timeout is counted from the pop cycle, so an idle UART yields a 3-cycle cadence.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_tx_start <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_tx_data  <= w_fifo_rdata;
                        r_tx_start <= 1'b1;
                        r_wait_cnt <= WaitCntW'(1);
                        r_state    <= StWaitBusy;
                    end
                end
                StWaitBusy: begin
                    if (i_tx_busy || (r_wait_cnt >= WaitCntW'(BusyTimeout - 1))) begin
                        r_state <= StWaitDone;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (!i_tx_busy) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hb_cnt    <= '0;
            r_heartbeat <= 1'b0;
        end else if (r_hb_cnt == HbW'(HB_DIV - 1)) begin
            r_hb_cnt    <= '0;
            r_heartbeat <= ~r_heartbeat;
        end else begin
            r_hb_cnt <= r_hb_cnt + 1'b1;
        end
    end

    assign o_proc_en   = r_proc_en;
    assign o_proc_in   = r_proc_in;
    assign o_tx_start  = r_tx_start;
    assign o_tx_data   = r_tx_data;
    assign o_overflow  = r_overflow;
    assign o_heartbeat = r_heartbeat;

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Scoreboard bench: stimulus pushes expected tx bytes, a monitor pops them on each tx_start.
module tb_uart_stream_bridge;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned PROC_LAT = 3;
    localparam int unsigned HB_DIV   = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   rx_done;
    logic [DATA_W-1:0]      rx_data;
    logic                   bypass;
    logic                   proc_en;
    logic [DATA_W-1:0]      proc_in;
    logic [DATA_W-1:0]      proc_out;
    logic                   tx_busy;
    logic                   tx_start;
    logic [DATA_W-1:0]      tx_data;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   overflow;
    logic                   heartbeat;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int tx_count = 0;
    int tx_times[$];
    logic [DATA_W-1:0] exp_q[$];

    bit force_busy = 1'b0;
    int busy_max   = 0;

    logic [PROC_LAT-1:0][DATA_W-1:0] stub;

    uart_stream_bridge #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .PROC_LAT (PROC_LAT),
        .HB_DIV   (HB_DIV)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_done    (rx_done),
        .i_rx_data    (rx_data),
        .i_bypass     (bypass),
        .o_proc_en    (proc_en),
        .o_proc_in    (proc_in),
        .i_proc_out   (proc_out),
        .i_tx_busy    (tx_busy),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .o_fifo_level (fifo_level),
        .o_overflow   (overflow),
        .o_heartbeat  (heartbeat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Processor stub: bitwise inverse, PROC_LAT cycles after proc_in is presented.
    always @(posedge clk) stub <= {stub[PROC_LAT-2:0], ~proc_in};
    assign proc_out = stub[PROC_LAT-1];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // UART transmitter model: busy for a random 0..busy_max cycles after each tx_start.
    initial begin
        int busy_cnt;
        busy_cnt = 0;
        tx_busy  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) busy_cnt = 0;
            else if (tx_start === 1'b1) busy_cnt = $urandom_range(busy_max, 0);
            tx_busy = force_busy || (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
        end
    end

    // Monitor: every tx_start pops one expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx_start === 1'b1) begin
                tx_count++;
                tx_times.push_back(cyc + 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_tx: got %0h expected no transmit (cycle %0d)",
                             tx_data, cyc);
                end else begin
                    check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic byp, input bit exp_tx,
                             input int gap);
        @(posedge clk);
        #1;
        rx_data = d;
        bypass  = byp;
        rx_done = 1'b1;
        if (exp_tx) exp_q.push_back(byp ? d : ~d);
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
        bypass  = 1'($urandom);
        repeat (gap) @(posedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        repeat (8) @(posedge clk);
    endtask

    initial begin
        int k;
        int r;
        int base;
        rst     = 1'b1;
        rx_done = 1'b0;
        rx_data = '0;
        bypass  = 1'b0;

        // Reset values and heartbeat cadence.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        k   = cyc;
        @(negedge clk);
        check("rst_proc_en", proc_en, 0);
        check("rst_proc_in", proc_in, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        for (int j = 0; j < 22; j++) begin
            check("heartbeat", heartbeat, ((cyc - k) / HB_DIV) % 2);
            @(negedge clk);
        end

        // Single processed byte with timing.
        busy_max = 0;
        tx_times.delete();
        @(posedge clk);
        #1;
        rx_data = 8'h3C;
        bypass  = 1'b0;
        rx_done = 1'b1;
        r = cyc + 1;
        exp_q.push_back(8'hC3);
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        @(negedge clk);
        check("proc_en_at_R1", proc_en, 1);
        check("proc_in_at_R1", proc_in, 8'h3C);
        @(negedge clk);
        check("proc_en_pulse", proc_en, 0);
        drain();
        check("tx_count_single", tx_times.size(), 1);
        if (tx_times.size() > 0) check("tx_start_time", tx_times[0], r + 3 + PROC_LAT);

        // Bypass and ordering.
        busy_max = 2;
        send_byte(8'h11, 1'b1, 1'b1, 0);
        send_byte(8'h22, 1'b0, 1'b1, 0);
        send_byte(8'h33, 1'b1, 1'b1, 0);
        drain();

        // Busy never asserted: timeout path gives a 3-cycle cadence.
        busy_max = 0;
        tx_times.delete();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'($urandom), 1'b1, 0);
        drain();
        check("timeout_tx_count", tx_times.size(), 4);
        for (int i = 1; i < tx_times.size(); i++) begin
            check("tx_spacing", tx_times[i] - tx_times[i-1], 3);
        end

        // Randomised bursts with a randomly busy UART.
        busy_max = 4;
        for (int b = 0; b < 10; b++) begin
            int n;
            n = $urandom_range(3, 1);
            for (int i = 0; i < n; i++) begin
                send_byte(8'($urandom), 1'($urandom), 1'b1, $urandom_range(3, 0));
            end
            drain();
        end
        check("random_no_overflow", overflow, 0);
        check("random_level_empty", fifo_level, 0);

        // Overflow: transmitter held busy, six bytes offered to a four-entry FIFO.
        force_busy = 1'b1;
        repeat (4) @(posedge clk);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'($urandom), 1'b1, 1);
        repeat (8) @(posedge clk);
        check("ovf_level_full", fifo_level, DEPTH);
        check("ovf_not_yet", overflow, 0);
        send_byte(8'($urandom), 1'($urandom), 1'b0, 1);
        repeat (8) @(posedge clk);
        check("ovf_set", overflow, 1);
        check("ovf_level_held", fifo_level, DEPTH);
        send_byte(8'($urandom), 1'($urandom), 1'b0, 1);
        repeat (8) @(posedge clk);
        base = tx_count;
        #1;
        force_busy = 1'b0;
        drain();
        repeat (20) @(posedge clk);
        check("ovf_tx_count", tx_count - base, DEPTH);
        check("ovf_sticky", overflow, 1);

        // Reset mid-flight with rx_done held high.
        force_busy = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'($urandom), 1'b1, 1);
        repeat (8) @(posedge clk);
        check("pre_rst_level", fifo_level, 3);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'h5A;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst        = 1'b0;
        force_busy = 1'b0;
        @(negedge clk);
        check("mid_rst_proc_en", proc_en, 0);
        check("mid_rst_proc_in", proc_in, 0);
        check("mid_rst_tx_start", tx_start, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_heartbeat", heartbeat, 0);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            check("held_rx_no_capture", proc_en, 0);
        end
        check("held_rx_level", fifo_level, 0);
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        send_byte(8'hA7, 1'b0, 1'b1, 2);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
